// File: rtl/lfsr_prpg_pkg.sv
// Shared types and helpers for the LFSR pattern generator.
package lfsr_prpg_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } lfsr_state_e;

  // Default feedback masks for a few common widths; other widths fall back to the
  // end taps (top and bottom bit).
  function automatic logic [31:0] default_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0005;
      4:       taps = 32'h0000_0009;
      5:       taps = 32'h0000_0012;
      8:       taps = 32'h0000_00b8;
      16:      taps = 32'h0000_b400;
      32:      taps = 32'h8020_0003;
      default: taps = (32'h1 << (width - 1)) | 32'h1;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_prpg_if.sv
// Control/data bundle of the LFSR pattern generator.
// LFSR_MISR_EN adds the data_in compaction input.
interface lfsr_prpg_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic             stop;
  logic             en;
  logic             load_valid;
  logic [WIDTH-1:0] load_seed;
  logic             load_ready;
  logic [WIDTH-1:0] out;
  logic             running;
  logic             period_done;
  logic [WIDTH-1:0] period;
  logic             lockup;
`ifdef LFSR_MISR_EN
  logic [WIDTH-1:0] data_in;
`endif

  // Driver side (test controller).
  modport master (
    output start, stop, en, load_valid, load_seed,
`ifdef LFSR_MISR_EN
    output data_in,
`endif
    input  load_ready, out, running, period_done, period, lockup
  );

  // Generator side.
  modport slave (
    input  start, stop, en, load_valid, load_seed,
`ifdef LFSR_MISR_EN
    input  data_in,
`endif
    output load_ready, out, running, period_done, period, lockup
  );

endinterface

// File: rtl/lfsr_prpg_step.sv
// Combinational Fibonacci LFSR next-state: shift left, parity of tapped bits into bit 0.
// LFSR_MISR_EN folds data_i into the result for signature compaction.
module lfsr_prpg_step #(
  parameter int unsigned     WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(4'b1001)
) (
  input  logic [WIDTH-1:0] state_i,
`ifdef LFSR_MISR_EN
  input  logic [WIDTH-1:0] data_i,
`endif
  output logic [WIDTH-1:0] nxt_o
);

  // Next state from current state (and optional compaction data).
  always_comb begin
    nxt_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
`ifdef LFSR_MISR_EN
    nxt_o = nxt_o ^ data_i;
`endif
  end

endmodule

// File: rtl/lfsr_prpg.sv
// Parametrised LFSR pattern generator with seed load, start/stop, step enable,
// period measurement and all-zero lockup detection.
// LFSR_MISR_EN: adds data_in compaction (MISR mode), lockup recovery suppressed.
module lfsr_prpg
  import lfsr_prpg_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input logic         clk,
  input logic         rst,
  lfsr_prpg_if.slave  bus
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  lfsr_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_done_q, period_done_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] step_val;

  lfsr_prpg_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state_i (out_q),
`ifdef LFSR_MISR_EN
    .data_i  (bus.data_in),
`endif
    .nxt_o   (nxt)
  );

  // FSM, seed load, stepping, period and lockup next-state.
  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    ref_d         = ref_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    period_done_d = 1'b0;
    lockup_d      = lockup_q;
    step_val      = nxt;
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          // An all-zero seed would lock the register up, so substitute SEED.
          out_d    = (bus.load_seed == '0) ? SEED : bus.load_seed;
          lockup_d = 1'b0;
        end
        if (bus.start) begin
          state_d = StRun;
          ref_d   = out_d;  // a seed loaded this cycle becomes the reference
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (out_q == '0) begin
          lockup_d = 1'b1;
        end
        if (bus.en) begin
`ifndef LFSR_MISR_EN
          if (out_q == '0) begin
            step_val = SEED;
          end
`endif
          out_d = step_val;
          if (step_val == ref_q) begin
            period_done_d = 1'b1;
            period_d      = cnt_q + One;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
        if (bus.stop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      out_q         <= SEED;
      ref_q         <= SEED;
      cnt_q         <= '0;
      period_q      <= '0;
      period_done_q <= 1'b0;
      lockup_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      ref_q         <= ref_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      period_done_q <= period_done_d;
      lockup_q      <= lockup_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.running     = (state_q == StRun);
  assign bus.load_ready  = (state_q == StIdle);
  assign bus.period_done = period_done_q;
  assign bus.period      = period_q;
  assign bus.lockup      = lockup_q;

endmodule
